// File: rtl/uart_pkg.sv
// Shared types and helpers for the wide-word UART transmitter.
package uart_pkg;

    // Line level while no frame is on the wire.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Byte engine: one state per frame field.
    typedef enum logic [2:0] {
        BYTE_IDLE   = 3'd0,
        BYTE_START  = 3'd1,
        BYTE_DATA   = 3'd2,
        BYTE_PARITY = 3'd3,
        BYTE_STOP   = 3'd4
    } byte_state_t;

    // Word sequencer: waiting for a word, or walking its bytes.
    typedef enum logic {
        WORD_IDLE = 1'b0,
        WORD_SEND = 1'b1
    } word_state_t;

    // Number of bit periods in one frame: start + 8 data + parity + stop.
    function automatic int uart_frame_bits(input int parity_en, input int stop_bits);
        return 1 + 8 + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART frame generator with built-in baud divider.
// A frame is loaded whenever the engine is idle, or on the final stop-bit
// cycle, while start is high; this lets the caller chain frames with no gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    byte_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [7:0]        byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              baud_wrap;
    logic              load;

    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;
    assign done      = done_q;

    // State, counters and the registered line output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BYTE_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            byte_q  <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter advance and the line level for the next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        load    = 1'b0;
        tx_d    = UART_IDLE_LEVEL;

        case (state_q)
            BYTE_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            BYTE_START: begin
                if (baud_wrap) begin
                    state_d = BYTE_DATA;
                    bit_d   = '0;
                end
            end
            BYTE_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? BYTE_PARITY : BYTE_STOP;
                        bit_d   = '0;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            BYTE_PARITY: begin
                if (baud_wrap) begin
                    state_d = BYTE_STOP;
                    stop_d  = 1'b0;
                end
            end
            BYTE_STOP: begin
                if (baud_wrap) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        stop_d = 1'b0;
                        if (start) begin
                            load = 1'b1;
                        end else begin
                            state_d = BYTE_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BYTE_IDLE;
            end
        endcase

        // Baud counter free-runs through a frame and rests at 0 when idle.
        if (state_q != BYTE_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        // A new frame always begins with a full-length start bit.
        if (load) begin
            state_d = BYTE_START;
            byte_d  = data;
            baud_d  = '0;
            bit_d   = '0;
        end

        case (state_d)
            BYTE_START:  tx_d = 1'b0;
            BYTE_DATA:   tx_d = byte_d[bit_d];
            BYTE_PARITY: tx_d = (^byte_d) ^ (PARITY_ODD != 0);
            BYTE_STOP:   tx_d = 1'b1;
            default:     tx_d = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: rtl/uart_word_tx.sv
// Wide-word UART transmitter: accepts one WORD_W-bit word and sends it as
// WORD_W/8 back-to-back frames through uart_byte_tx.
// Handshake: a word is taken on any rising edge where s_valid && s_ready;
// s_data is only looked at on that edge, and s_valid while busy is ignored.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_W       = 128,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              tx,
    output logic              busy,
    output logic              byte_done,
    output logic              word_done
);

    localparam int N_BYTES = WORD_W / 8;
    localparam int BCNT_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    word_state_t       word_q, word_d;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic [WORD_W-1:0] sr_q;
    logic              frame_done;
    logic              last_byte;
    logic              word_end;
    logic              accept;
    logic              byte_start;
    logic [7:0]        byte_data;

    // Byte presented to the wire next, according to the configured order.
    function automatic logic [7:0] head_byte(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_W-1 -: 8] : w[7:0];
    endfunction

    // Remove the head byte so the following one moves into its place.
    function automatic logic [WORD_W-1:0] drop_byte(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 8) : (w >> 8);
    endfunction

    // The byte counter equals the index of the frame on the wire except in
    // that frame's first cycle; frame ends never fall in that cycle, so
    // last_byte is exact whenever the engine decides whether to chain.
    assign last_byte  = (byte_cnt_q == BCNT_W'(N_BYTES - 1));
    assign word_end   = (word_q == WORD_SEND) && frame_done && last_byte;
    // Ready is raised in the word_done cycle so a new word can be taken
    // there, giving exactly one idle-high cycle between words.
    assign s_ready    = (word_q == WORD_IDLE) || word_end;
    assign busy       = !s_ready;
    assign accept     = s_valid && s_ready;
    // Byte 0 comes straight from s_data; later bytes come from the register,
    // which already holds the next byte at the head when a frame ends.
    assign byte_start = accept || ((word_q == WORD_SEND) && !last_byte);
    assign byte_data  = accept ? head_byte(s_data) : head_byte(sr_q);
    assign byte_done  = frame_done;
    assign word_done  = word_end;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN),
        .PARITY_ODD   (PARITY_ODD),
        .STOP_BITS    (STOP_BITS)
    ) u_byte_tx (
        .clk   (clk),
        .reset (reset),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .done  (frame_done)
    );

    // Word FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= WORD_IDLE;
        end else begin
            word_q <= word_d;
        end
    end

    // Word FSM next state: IDLE until a word arrives, SEND until its last frame.
    always_comb begin
        word_d = word_q;
        case (word_q)
            WORD_IDLE: begin
                if (accept) begin
                    word_d = WORD_SEND;
                end
            end
            WORD_SEND: begin
                if (word_end) begin
                    word_d = accept ? WORD_SEND : WORD_IDLE;
                end
            end
            default: begin
                word_d = WORD_IDLE;
            end
        endcase
    end

    // Shift register and byte counter: the register drops its head byte in
    // the cycle after each frame ends, which is when byte_done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            byte_cnt_q <= '0;
        end else if (accept) begin
            sr_q       <= drop_byte(s_data);
            byte_cnt_q <= '0;
        end else if ((word_q == WORD_SEND) && frame_done) begin
            sr_q       <= drop_byte(sr_q);
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: four configurations, one active at a
// time, checked cycle by cycle against a frame-level reference model.
module tb_uart_word_tx;

    localparam int NDUT = 4;
    localparam int CFG_W    [NDUT] = '{16, 16, 32, 128};
    localparam int CFG_CLK  [NDUT] = '{4, 4, 2, 16};
    localparam int CFG_PAR  [NDUT] = '{0, 1, 1, 0};
    localparam int CFG_ODD  [NDUT] = '{0, 0, 1, 0};
    localparam int CFG_STOP [NDUT] = '{1, 1, 2, 1};
    localparam int CFG_MSB  [NDUT] = '{1, 1, 0, 1};

    // Per-cycle observation: {tx, s_ready, busy, byte_done, word_done}.
    localparam int VW = 5;
    localparam logic [VW-1:0] IDLE_VEC = 5'b11000;

    logic           clk;
    logic           reset;
    logic [NDUT-1:0] s_valid_v;
    logic [127:0]   s_data_bus;
    logic [NDUT-1:0] ready_v, tx_v, busy_v, bdone_v, wdone_v;

    int sel;
    bit mon_en;
    int n_vec;
    int n_err;
    logic [VW-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    uart_word_tx #(.WORD_W(CFG_W[0]), .CLKS_PER_BIT(CFG_CLK[0]), .PARITY_EN(CFG_PAR[0]),
                   .PARITY_ODD(CFG_ODD[0]), .STOP_BITS(CFG_STOP[0]), .MSB_FIRST(CFG_MSB[0]))
    dut0 (.clk(clk), .reset(reset), .s_valid(s_valid_v[0]), .s_ready(ready_v[0]),
          .s_data(s_data_bus[CFG_W[0]-1:0]), .tx(tx_v[0]), .busy(busy_v[0]),
          .byte_done(bdone_v[0]), .word_done(wdone_v[0]));

    uart_word_tx #(.WORD_W(CFG_W[1]), .CLKS_PER_BIT(CFG_CLK[1]), .PARITY_EN(CFG_PAR[1]),
                   .PARITY_ODD(CFG_ODD[1]), .STOP_BITS(CFG_STOP[1]), .MSB_FIRST(CFG_MSB[1]))
    dut1 (.clk(clk), .reset(reset), .s_valid(s_valid_v[1]), .s_ready(ready_v[1]),
          .s_data(s_data_bus[CFG_W[1]-1:0]), .tx(tx_v[1]), .busy(busy_v[1]),
          .byte_done(bdone_v[1]), .word_done(wdone_v[1]));

    uart_word_tx #(.WORD_W(CFG_W[2]), .CLKS_PER_BIT(CFG_CLK[2]), .PARITY_EN(CFG_PAR[2]),
                   .PARITY_ODD(CFG_ODD[2]), .STOP_BITS(CFG_STOP[2]), .MSB_FIRST(CFG_MSB[2]))
    dut2 (.clk(clk), .reset(reset), .s_valid(s_valid_v[2]), .s_ready(ready_v[2]),
          .s_data(s_data_bus[CFG_W[2]-1:0]), .tx(tx_v[2]), .busy(busy_v[2]),
          .byte_done(bdone_v[2]), .word_done(wdone_v[2]));

    uart_word_tx #(.WORD_W(CFG_W[3]), .CLKS_PER_BIT(CFG_CLK[3]), .PARITY_EN(CFG_PAR[3]),
                   .PARITY_ODD(CFG_ODD[3]), .STOP_BITS(CFG_STOP[3]), .MSB_FIRST(CFG_MSB[3]))
    dut3 (.clk(clk), .reset(reset), .s_valid(s_valid_v[3]), .s_ready(ready_v[3]),
          .s_data(s_data_bus[CFG_W[3]-1:0]), .tx(tx_v[3]), .busy(busy_v[3]),
          .byte_done(bdone_v[3]), .word_done(wdone_v[3]));

    // ---------------- reference model ----------------
    // Expected waveform for one accepted word, starting the cycle after the
    // accepting edge: every frame field held CLKS_PER_BIT cycles, byte_done in
    // the first cycle of each later frame, then the shared done/ready cycle.
    task automatic push_word(input int d, input logic [127:0] w);
        int n;
        int fb;
        logic [7:0] b;
        logic bitv;
        n  = CFG_W[d] / 8;
        fb = 9 + CFG_PAR[d] + CFG_STOP[d];
        for (int k = 0; k < n; k++) begin
            b = (CFG_MSB[d] != 0) ? w[(n-1-k)*8 +: 8] : w[k*8 +: 8];
            for (int j = 0; j < fb; j++) begin
                if (j == 0)
                    bitv = 1'b0;
                else if (j <= 8)
                    bitv = b[j-1];
                else if (j == 9 && CFG_PAR[d] != 0)
                    bitv = (^b) ^ (CFG_ODD[d] != 0);
                else
                    bitv = 1'b1;
                for (int c = 0; c < CFG_CLK[d]; c++) begin
                    exp_q.push_back({bitv, 1'b0, 1'b1, (k > 0 && j == 0 && c == 0), 1'b0});
                end
            end
        end
        exp_q.push_back(5'b11011);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        if (mon_en) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_VEC;
            act_v = {tx_v[sel], ready_v[sel], busy_v[sel], bdone_v[sel], wdone_v[sel]};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_vec t=%0t dut=%0d tx/rdy/busy/bd/wd got=%b want=%b",
                         $time, sel, act_v, exp_v);
            end
            if (reset) begin
                exp_q.delete();
            end else if (s_valid_v[sel] && exp_v[3]) begin
                push_word(sel, s_data_bus);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!ready_v[sel] && g < 20000);
        if (g >= 20000) begin
            n_err++;
            $display("FAIL accept_timeout dut=%0d got=no_ready want=ready", sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] w);
        s_data_bus     = w;
        s_valid_v      = '0;
        s_valid_v[sel] = 1'b1;
        wait_accept();
        s_valid_v  = '0;
        s_data_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) begin
            n_err++;
            $display("FAIL idle_timeout dut=%0d got=%0d_pending want=0", sel, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_random(input int count);
        for (int i = 0; i < count; i++) begin
            send({$urandom(), $urandom(), $urandom(), $urandom()});
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        s_valid_v  = '0;
        s_data_bus = '0;
        sel        = 0;
        mon_en     = 1'b0;
        n_vec      = 0;
        n_err      = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Baseline 16-bit MSB-first word, then random traffic.
        sel = 0;
        send(128'hA55A);
        wait_idle();
        send_random(5);
        wait_idle();

        // Back-to-back words with s_valid held; s_data wiggles while busy.
        s_valid_v[0] = 1'b1;
        s_data_bus   = 128'h1234;
        wait_accept();
        s_data_bus = 128'hFFFF;
        repeat (20) @(posedge clk);
        #1;
        s_data_bus = 128'($urandom_range(0, 65535));
        repeat (20) @(posedge clk);
        #1;
        s_data_bus = 128'hABCD;
        wait_accept();
        s_data_bus = 128'h0F0F;
        repeat (10) @(posedge clk);
        #1;
        s_valid_v = '0;
        wait_idle();

        // Reset during the data bits of byte 0, then a clean word.
        send(128'hC3C3);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(128'h00FF);
        wait_idle();

        // Parity, even, LSB... byte order kept MSB first for the named words.
        sel = 1;
        send(128'hA5A5);
        wait_idle();
        send(128'h0701);
        wait_idle();
        send_random(4);
        wait_idle();

        // Odd parity, two stop bits, LSB-first byte order.
        sel = 2;
        send(128'hA55A_0701);
        wait_idle();
        send_random(4);
        wait_idle();

        // Full-width default configuration.
        sel = 3;
        send(128'h000102030405060708090A0B0C0D0E0F);
        wait_idle();
        send_random(1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
